// File: rtl/event_arb_pkg.sv
// Shared types and constants for the event-record source arbiter.
package event_arb_pkg;

    localparam int EVENT_REC_W = 256;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        SRC0     = 2'd1,
        SRC1     = 2'd2,
        RR       = 2'd3
    } arb_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Bit i set when the mode allows source i to be granted.
    function automatic logic [1:0] mode_enable(input arb_mode_t mode);
        logic [1:0] en;
        case (mode)
            DISABLED: en = 2'b00;
            SRC0:     en = 2'b01;
            SRC1:     en = 2'b10;
            RR:       en = 2'b11;
            default:  en = 2'b00;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/event_arb_rr_pick.sv
// Two-way picker: chooses among eligible sources, breaking ties away from the last winner.
module event_arb_rr_pick
    import event_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic [1:0] enable,
    input  logic       last,
    output logic       pick,
    output logic       any
);

    logic [1:0] elig_s;

    // Eligibility and tie-break selection
    always_comb begin
        elig_s = valid & enable;
        any    = |elig_s;
        if (elig_s == 2'b11) begin
            pick = ~last;
        end else if (elig_s[1]) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
    end

endmodule

// File: rtl/event_source_arbiter.sv
// Per-packet arbiter merging the UART bridge and event generator record streams
// into one registered AXI-Stream output, with per-source beat counters.
module event_source_arbiter
    import event_arb_pkg::*;
#(
    parameter int DATA_W = EVENT_REC_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic              cnt_clr,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic              s0_axis_tlast,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tvalid,
    output logic              s1_axis_tready,
    input  logic              s1_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_src,
    output logic [CNT_W-1:0]  cnt_s0,
    output logic [CNT_W-1:0]  cnt_s1,
    output logic              busy
);

    arb_state_t state_r;
    arb_state_t state_next_s;
    logic       rr_last_r;
    logic       rr_last_next_s;
    logic [1:0] enable_s;
    logic       pick_s;
    logic       any_s;
    logic       slot_free_s;
    logic       xfer0_s;
    logic       xfer1_s;
    logic       xfer_s;
    logic       xfer_last_s;

    assign enable_s    = mode_enable(arb_mode_t'(cfg_mode));
    assign slot_free_s = ~m_axis_tvalid | m_axis_tready;
    assign xfer0_s     = s0_axis_tvalid & s0_axis_tready;
    assign xfer1_s     = s1_axis_tvalid & s1_axis_tready;
    assign xfer_s      = xfer0_s | xfer1_s;
    assign xfer_last_s = xfer1_s ? s1_axis_tlast : s0_axis_tlast;

    event_arb_rr_pick u_pick (
        .valid  ({s1_axis_tvalid, s0_axis_tvalid}),
        .enable (enable_s),
        .last   (rr_last_r),
        .pick   (pick_s),
        .any    (any_s)
    );

    // Ready generation: the lock owner, or the IDLE pick when it is eligible
    always_comb begin
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state_r)
            IDLE: begin
                s0_axis_tready = slot_free_s & any_s & ~pick_s;
                s1_axis_tready = slot_free_s & any_s & pick_s;
            end
            LOCK0:   s0_axis_tready = slot_free_s;
            LOCK1:   s1_axis_tready = slot_free_s;
            default: s0_axis_tready = 1'b0;
        endcase
    end

    // Next-state: lock on a non-final beat, release and remember the winner on tlast
    always_comb begin
        state_next_s   = state_r;
        rr_last_next_s = rr_last_r;
        if (xfer_s) begin
            if (xfer_last_s) begin
                state_next_s   = IDLE;
                rr_last_next_s = xfer1_s;
            end else if (xfer1_s) begin
                state_next_s = LOCK1;
            end else begin
                state_next_s = LOCK0;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // State, round-robin memory and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            rr_last_r <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            rr_last_r <= rr_last_next_s;
            busy      <= (state_next_s != IDLE);
        end
    end

    // Registered output slot; data and source index hold after the beat drains
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_src         <= 1'b0;
        end else if (xfer_s) begin
            m_axis_tdata  <= xfer1_s ? s1_axis_tdata : s0_axis_tdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= xfer_last_s;
            m_src         <= xfer1_s;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            m_axis_tvalid <= m_axis_tvalid;
        end
    end

    // Accepted-beat counters; clear takes priority over a same-cycle transfer
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_s0 <= '0;
            cnt_s1 <= '0;
        end else begin
            if (xfer0_s) begin
                cnt_s0 <= cnt_s0 + CNT_W'(1);
            end else begin
                cnt_s0 <= cnt_s0;
            end
            if (xfer1_s) begin
                cnt_s1 <= cnt_s1 + CNT_W'(1);
            end else begin
                cnt_s1 <= cnt_s1;
            end
        end
    end

endmodule

// File: tb/tb_event_source_arbiter.sv
// Self-checking bench for event_source_arbiter: vector table, directed corner
// sequences and randomized traffic against a rule-level reference model.
module tb_event_source_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   cfg_mode;
    logic         cnt_clr;
    logic [255:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic         s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
    logic         s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast, m_src, busy;
    logic [31:0]  cnt_s0, cnt_s1;

    always #5 clk = ~clk;

    event_source_arbiter dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cnt_clr(cnt_clr),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tready(s0_axis_tready), .s0_axis_tlast(s0_axis_tlast),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tready(s1_axis_tready), .s1_axis_tlast(s1_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_src(m_src), .cnt_s0(cnt_s0), .cnt_s1(cnt_s1), .busy(busy)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: packet owner (-1 = none), last winner, output slot, counters
    int           m_owner;
    bit           m_rr, m_v, m_l, m_s;
    logic [255:0] m_d;
    logic [31:0]  m_c0, m_c1;
    bit           smp_r0, smp_r1;
    logic [31:0]  tick = 32'd0;
    bit           use_fix0 = 1'b0;
    logic [255:0] fix0;

    typedef struct {
        logic [1:0] mode;
        bit v0, l0, v1, l1, mtr;
        bit er0, er1, es;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("m_axis_tvalid", 256'(m_axis_tvalid), 256'(m_v));
        chk("m_axis_tlast", 256'(m_axis_tlast), 256'(m_l));
        chk("m_src", 256'(m_src), 256'(m_s));
        chk("m_axis_tdata", m_axis_tdata, m_d);
        chk("cnt_s0", 256'(cnt_s0), 256'(m_c0));
        chk("cnt_s1", 256'(cnt_s1), 256'(m_c1));
        chk("busy", 256'(busy), 256'(m_owner != -1));
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 1'b1; m_v = 1'b0; m_l = 1'b0; m_s = 1'b0;
        m_d = '0; m_c0 = 32'd0; m_c1 = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_tlast", 256'(m_axis_tlast), 256'(0));
        chk("rst_src", 256'(m_src), 256'(0));
        chk("rst_tdata", m_axis_tdata, 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_cnt", 256'({cnt_s0, cnt_s1}), 256'(0));
    endtask

    // One clock cycle: drive, check readies against the model, clock, check outputs
    task automatic cycle(input logic [1:0] mode, input bit v0, input bit l0, input bit v1,
                         input bit l1, input bit mtr, input bit clr);
        bit slot, e0, e1, er0, er1, x1;
        cfg_mode = mode; cnt_clr = clr; m_axis_tready = mtr;
        s0_axis_tvalid = v0; s0_axis_tlast = l0;
        s1_axis_tvalid = v1; s1_axis_tlast = l1;
        s0_axis_tdata = use_fix0 ? fix0 : {8{tick ^ 32'h5A00_0000}};
        s1_axis_tdata = {8{~tick}};
        tick = tick + 32'd1;
        @(negedge clk);
        slot = !m_v || mtr;
        er0 = 1'b0; er1 = 1'b0;
        if (m_owner == 0) er0 = slot;
        else if (m_owner == 1) er1 = slot;
        else begin
            e0 = v0 && (mode == 2'd1 || mode == 2'd3);
            e1 = v1 && (mode == 2'd2 || mode == 2'd3);
            if (e0 && e1) begin
                if (m_rr) er0 = slot; else er1 = slot;
            end else if (e0) er0 = slot;
            else if (e1) er1 = slot;
        end
        smp_r0 = s0_axis_tready; smp_r1 = s1_axis_tready;
        chk("tready", 256'({smp_r0, smp_r1}), 256'({er0, er1}));
        if ((er0 && v0) || (er1 && v1)) begin
            x1 = er1 && v1;
            m_d = x1 ? s1_axis_tdata : s0_axis_tdata;
            m_l = x1 ? l1 : l0;
            m_s = x1; m_v = 1'b1;
            m_owner = m_l ? -1 : int'(x1);
            if (m_l) m_rr = x1;
            if (x1) m_c1 = m_c1 + 32'd1; else m_c0 = m_c0 + 32'd1;
        end else if (mtr) begin
            m_v = 1'b0; m_l = 1'b0;
        end
        if (clr) begin m_c0 = 32'd0; m_c1 = 32'd0; end
        @(posedge clk); #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] snap0, snap1;
        cfg_mode = 2'd0; cnt_clr = 1'b0; m_axis_tready = 1'b0;
        s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0; s0_axis_tdata = '0;
        s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0; s1_axis_tdata = '0;
        fix0 = {32{8'hA5}};
        do_reset();

        // Round-robin alternation of single-beat records
        for (int i = 0; i < 8; i++)
            tbl[i] = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, (i % 2 == 0), (i % 2 == 1), (i % 2 == 1)};
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].mode, tbl[i].v0, tbl[i].l0, tbl[i].v1, tbl[i].l1, tbl[i].mtr, 1'b0);
            chk("tbl_ready", 256'({smp_r0, smp_r1}), 256'({tbl[i].er0, tbl[i].er1}));
            chk("tbl_src", 256'(m_src), 256'(tbl[i].es));
            chk("tbl_valid", 256'(m_axis_tvalid), 256'(1));
        end
        chk("rr_cnt_s0", 256'(cnt_s0), 256'(4));
        chk("rr_cnt_s1", 256'(cnt_s1), 256'(4));

        // Three-beat source-1 packet while source 0 stays valid
        cycle(2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("pkt_pre", 256'({smp_r0, smp_r1}), 256'(2'b10));
        for (int b = 0; b < 3; b++) begin
            cycle(2'd3, 1'b1, 1'b1, 1'b1, (b == 2), 1'b1, 1'b0);
            chk("pkt_s1_ready", 256'({smp_r0, smp_r1}), 256'(2'b01));
            chk("pkt_s1_src", 256'(m_src), 256'(1));
        end
        cycle(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pkt_post_s0", 256'({smp_r0, smp_r1}), 256'(2'b10));

        // Backpressure on a pending 0xA5 beat
        use_fix0 = 1'b1;
        cycle(2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int s = 0; s < 5; s++) begin
            cycle(2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("bp_ready", 256'({smp_r0, smp_r1}), 256'(2'b00));
            chk("bp_data", m_axis_tdata, {32{8'hA5}});
            chk("bp_src", 256'(m_src), 256'(0));
        end
        use_fix0 = 1'b0;
        cycle(2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("bp_accept", 256'({smp_r0, smp_r1}), 256'(2'b01));

        // Mode change from round-robin to source 0 during a source-1 lock
        cycle(2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sw_lock_ready", 256'({smp_r0, smp_r1}), 256'(2'b01));
        cycle(2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("sw_last_ready", 256'({smp_r0, smp_r1}), 256'(2'b01));
        for (int k = 0; k < 4; k++) begin
            cycle(2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            chk("sw_after_ready", 256'({smp_r0, smp_r1}), 256'(2'b10));
        end

        // Disabled mode: nothing is granted, the last beat drains
        snap0 = m_c0; snap1 = m_c1;
        for (int k = 0; k < 10; k++) begin
            cycle(2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            chk("dis_ready", 256'({smp_r0, smp_r1}), 256'(2'b00));
            chk("dis_valid", 256'(m_axis_tvalid), 256'(0));
        end
        chk("dis_cnt", 256'({cnt_s0, cnt_s1}), 256'({snap0, snap1}));

        // Reset mid-packet, then clear colliding with a transfer
        cycle(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mid_busy", 256'(busy), 256'(1));
        do_reset();
        cycle(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_wins", 256'(cnt_s0), 256'(0));
        chk("clr_valid", 256'(m_axis_tvalid), 256'(1));

        // Randomized traffic against the model
        begin
            logic [1:0] rmode;
            rmode = 2'd3;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(7) == 0) rmode = 2'($urandom_range(3));
                if ($urandom_range(499) == 0) do_reset();
                cycle(rmode, ($urandom_range(3) != 0), ($urandom_range(2) == 0),
                      ($urandom_range(3) != 0), ($urandom_range(2) == 0),
                      ($urandom_range(3) != 0), ($urandom_range(49) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/event_source_arbiter.md
# event_source_arbiter

Two-input packet arbiter that shares the single 256-bit event-record stream feeding the record unpacker between the UART bridge (source 0) and the internal event generator (source 1). Grants are per packet (held until `tlast`) and selected by a runtime mode: disabled, fixed source, or round-robin. The output is a registered AXI-Stream slot. Per-source accepted-beat counters are provided for bring-up visibility.

## Interface
Parameters:
- `DATA_W`, 256, record width
- `CNT_W`, 32, width of each beat counter

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `cfg_mode`  in  2  0 = disabled, 1 = source 0 only, 2 = source 1 only, 3 = round-robin
- `cnt_clr`  in  1  synchronous clear of both counters
- `s0_axis_tdata`, `s0_axis_tvalid`, `s0_axis_tready`, `s0_axis_tlast`  in/in/out/in  DATA_W/1/1/1  UART bridge stream
- `s1_axis_tdata`, `s1_axis_tvalid`, `s1_axis_tready`, `s1_axis_tlast`  in/in/out/in  DATA_W/1/1/1  generator stream
- `m_axis_tdata`, `m_axis_tvalid`, `m_axis_tready`, `m_axis_tlast`  out/out/in/out  DATA_W/1/1/1  to unpacker
- `m_src`  out  1  source index of the beat currently in `m_axis_tdata`
- `cnt_s0`, `cnt_s1`  out  CNT_W  beats accepted from each source
- `busy`  out  1  high while a packet lock is held (state ≠ IDLE)

## Operation
- `slot_free = !m_axis_tvalid || m_axis_tready`.
- FSM states:
  - IDLE: no grant is held.
  - LOCK0: source 0 owns the output.
  - LOCK1: source 1 owns the output.
- Eligibility: source i is eligible when `cfg_mode` permits it (mode 3 permits both) and `si_axis_tvalid` is high. `cfg_mode` is sampled only in IDLE. A mode change during a lock takes effect after that packet's `tlast` beat.
- IDLE pick:
  - Only one source eligible: pick it.
  - Both eligible: pick the source ≠ `rr_last`.
- Grant and ready:
  - `grant = pick` in IDLE, `grant = i` in LOCKi.
  - `si_axis_tready = slot_free && grant == i && (state == LOCKi || source i eligible)`.
  - Only one `tready` is ever high.
- Transfer on source i (`tvalid && tready`):
  - Output registers load `tdata`/`tlast` from source i.
  - `m_src <= i`; `m_axis_tvalid <= 1`.
  - `cnt_si` increments, wrapping modulo 2^CNT_W.
- State transitions:
  - Transfer with `tlast = 0`: go to LOCKi (or stay there).
  - Transfer with `tlast = 1`: go to IDLE; `rr_last <= i`.
  - A single-beat packet therefore goes IDLE → IDLE.
- Output slot:
  - Output consumed with no new transfer: `m_axis_tvalid <= 0`, `m_axis_tlast <= 0`.
  - `m_axis_tdata` and `m_src` hold their last values.
- In LOCKi the other source is never granted, even if the lock owner is idle (no `tvalid`).
- Mode 0 in IDLE: no grants, both `tready` low. An existing output beat still drains.
- `cnt_clr` and a transfer in the same cycle: clear wins, counter = 0.
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `m_src`, `m_axis_tdata`, `busy` = 0.
  - `cnt_s0`, `cnt_s1` = 0.
  - State = IDLE; `rr_last` = 1, so source 0 wins the first tie.
- Reset mid-packet drops the lock and any held output beat; the partial packet is not completed.

## Timing
- Latency: one cycle from input handshake to `m_axis_tvalid`.
- Throughput: one beat per cycle while `m_axis_tready` stays high, including back-to-back packets from alternating sources.
- `tready` outputs are combinational from state, `rr_last`, `cfg_mode`, the input `tvalid`s and `m_axis_tready`. No combinational path from any `tdata` to any output.
- Output holds `tdata`/`tlast`/`m_src` stable while `m_axis_tvalid && !m_axis_tready`.
- Counters, `busy` and `m_src` update on the clock edge that completes the transfer.

## Structure
- Package `event_arb_pkg`:
  - `arb_mode_t` enum (DISABLED, SRC0, SRC1, RR)
  - `arb_state_t` enum (IDLE, LOCK0, LOCK1)
  - `EVENT_REC_W = 256`
- Sub-module `event_arb_rr_pick`: a small combinational 2-way picker taking `valid[1:0]`, `enable[1:0]` and `last` to produce `pick` and `any`. Everything else lives in the top module.

## Test plan
- Mode 3, both sources hold single-beat records, `m_axis_tready = 1`:
  - Grants alternate 0, 1, 0, 1; one beat per cycle.
  - After 8 cycles, `cnt_s0 = 4` and `cnt_s1 = 4`.
- Mode 3, source 1 sends a 3-beat packet while source 0 is valid throughout:
  - All 3 source-1 beats go out contiguously with `m_src = 1`.
  - Source 0 is granted on the cycle after source 1's `tlast`.
- Backpressure: hold `m_axis_tready = 0` for 5 cycles with an output beat `0xA5…A5` pending:
  - `tdata`/`m_src` stay stable and both `tready`s stay low.
  - The beat is accepted on the first cycle `m_axis_tready` goes high.
- Switch `cfg_mode` from 3 to 1 while LOCK1 is held:
  - The source-1 packet completes.
  - Afterwards only source 0 is granted; `s1_axis_tready` stays 0.
- Mode 0: both sources valid for 10 cycles:
  - No transfers; counters unchanged; `m_axis_tvalid = 0`.
- Assert `rst` mid-packet, then pulse `cnt_clr` in the same cycle as a transfer:
  - All outputs reset to their reset values.
  - The counter reads 0 after the `cnt_clr` cycle.
